pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-specifier width.
REQ-002 SHALL have parameter MISS_MAX, default 8, the MISS_WAIT cycle count at which miss_err sets.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port hit_fetch, input, 1 bit: 1 = instruction in IF/ID is valid (icache hit).
REQ-006 SHALL have port miss_done, input, 1 bit: one-cycle pulse when icache refill completes.
REQ-007 SHALL have ports id_rs1 and id_rs2, input, REG_W each: source registers of the instruction in ID.
REQ-008 SHALL have port ex_rd, input, REG_W: destination register of the instruction in EX.
REQ-009 SHALL have port ex_mem_read, input, 1 bit: the instruction in EX is a load.
REQ-010 SHALL have port branch_taken, input, 1 bit: taken branch resolved in EX this cycle.
REQ-011 SHALL have port pc_write, output, 1 bit: PC update enable.
REQ-012 SHALL have port ifid_write, output, 1 bit: IF/ID capture enable.
REQ-013 SHALL have port ifid_flush, output, 1 bit: IF/ID contents are replaced by a NOP.
REQ-014 SHALL have port idex_bubble, output, 1 bit: a NOP is inserted into ID/EX.
REQ-015 SHALL have port miss_err, output, 1 bit: sticky miss-timeout flag.

Function
REQ-016 SHALL implement a registered FSM with states RUN, MISS_WAIT and FLUSH.
REQ-017 SHALL compute pc_write, ifid_write, ifid_flush and idex_bubble combinationally from the current state and inputs, with zero-cycle latency.
REQ-018 SHALL define load_use = ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
REQ-019 In RUN, SHALL apply this priority: branch_taken > !hit_fetch > load_use > normal.
REQ-020 In RUN with branch_taken: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state RUN.
REQ-021 In RUN with !hit_fetch and no branch_taken: pc_write=0, ifid_write=0, idex_bubble=1; next state MISS_WAIT.
REQ-022 In RUN with load_use only: pc_write=0, ifid_write=0, idex_bubble=1 for exactly one cycle; next state RUN.
REQ-023 In RUN with normal flow: pc_write=1, ifid_write=1, ifid_flush=0, idex_bubble=0.
REQ-024 In MISS_WAIT: ifid_write=0, idex_bubble=1, and pc_write=branch_taken.
REQ-025 In MISS_WAIT, branch_taken SHALL set internal flush_pend.
REQ-026 In MISS_WAIT with miss_done=1: next state is FLUSH if flush_pend or branch_taken is set, else RUN; flush_pend clears.
REQ-027 In FLUSH (exactly one cycle): pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=1; next state RUN.
REQ-028 branch_taken in FLUSH SHALL produce the same outputs; the state SHALL still return to RUN.
REQ-029 SHALL keep a miss counter, width clog2(MISS_MAX+1), that clears on MISS_WAIT entry, increments each MISS_WAIT cycle, and saturates at MISS_MAX.
REQ-030 Reaching MISS_MAX SHALL set miss_err; miss_err holds until reset and SHALL NOT alter the FSM.
REQ-031 A miss_done pulse outside MISS_WAIT SHALL be ignored.

Reset
REQ-032 rst_n=0 SHALL immediately force: state RUN, flush_pend=0, miss counter=0, miss_err=0, stall_cycles=0.
REQ-033 During reset, outputs SHALL follow the RUN decode of the current inputs.
REQ-034 Reset asserted mid-MISS_WAIT SHALL discard any pending flush.

Configuration
REQ-035 With macro PIPELINE_CTRL_STALL_CNT_EN defined, SHALL add output stall_cycles (16 bits).
REQ-036 stall_cycles SHALL increment on every cycle with pc_write=0 and saturate at 16'hFFFF.
REQ-037 Without PIPELINE_CTRL_STALL_CNT_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Load-use: RUN, ex_mem_read=1, ex_rd=3, id_rs2=3 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1, then normal; with ex_rd=0 -> no stall.
REQ-039 Miss: hit_fetch=0 for one cycle, miss_done pulses 4 cycles later -> pc_write=0 for 5 cycles, back in RUN, miss_err=0.
REQ-040 Branch during miss: branch_taken in the 2nd MISS_WAIT cycle, then miss_done -> pc_write=1 in the branch cycle, one FLUSH cycle with ifid_flush=1, then RUN.
REQ-041 Priority: branch_taken=1, hit_fetch=0, load_use=1 together in RUN -> flush outputs only, state stays RUN.
REQ-042 Timeout: MISS_MAX=8, miss_done withheld 10 cycles -> miss_err=1 after cycle 8, still 1 after exit; rst_n low mid-miss -> state RUN, miss_err=0.
REQ-043 With PIPELINE_CTRL_STALL_CNT_EN defined, 3 stall cycles -> stall_cycles=3.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: load-use stalls, icache miss waits and branch flushes.
// Optional stall-cycle counter output enabled by defining PIPELINE_CTRL_STALL_CNT_EN.
module pipeline_ctrl #(
  parameter int REG_W    = 3,
  parameter int MISS_MAX = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hit_fetch,
  input  logic             miss_done,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mem_read,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             miss_err
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  ,
  output logic [15:0]      stall_cycles
`endif
);

  localparam int CNT_W = $clog2(MISS_MAX + 1);

  typedef enum logic [1:0] {RUN, MISS_WAIT, FLUSH} state_t;

  state_t           state;
  logic             flush_pend;
  logic [CNT_W-1:0] miss_cnt;
  logic             load_use;

  assign load_use = ex_mem_read & (ex_rd != '0) &
                    ((ex_rd == id_rs1) | (ex_rd == id_rs2));

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    case (state)
      RUN: begin
        if (branch_taken) begin
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
        end else if (!hit_fetch || load_use) begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_bubble = 1'b1;
        end
      end
      MISS_WAIT: begin
        // The redirect PC is taken now; the stale fetch is flushed after the refill.
        pc_write    = branch_taken;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
      FLUSH: begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end
      default: begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= RUN;
      flush_pend <= 1'b0;
      miss_cnt   <= '0;
      miss_err   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (!branch_taken && !hit_fetch) begin
            state    <= MISS_WAIT;
            miss_cnt <= '0;
          end
        end
        MISS_WAIT: begin
          if (miss_cnt != CNT_W'(MISS_MAX))
            miss_cnt <= miss_cnt + CNT_W'(1);
          // miss_err is purely diagnostic and never steers the FSM.
          if (miss_cnt >= CNT_W'(MISS_MAX - 1))
            miss_err <= 1'b1;
          if (miss_done) begin
            state      <= (flush_pend || branch_taken) ? FLUSH : RUN;
            flush_pend <= 1'b0;
          end else if (branch_taken) begin
            flush_pend <= 1'b1;
          end
        end
        FLUSH: state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPELINE_CTRL_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (!pc_write && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; outputs are checked mid-cycle
// as the nibble {pc_write, ifid_write, ifid_flush, idex_bubble}.
module tb_pipeline_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       hit_fetch, miss_done, ex_mem_read, branch_taken;
  logic [2:0] id_rs1, id_rs2, ex_rd;
  logic       pc_write, ifid_write, ifid_flush, idex_bubble, miss_err;
`ifdef PIPELINE_CTRL_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks   = 0;
  int failures = 0;

  localparam logic [3:0] NORM  = 4'b1100;
  localparam logic [3:0] STALL = 4'b0001;
  localparam logic [3:0] FLSH  = 4'b1111;
  localparam logic [3:0] BRMW  = 4'b1001;

  pipeline_ctrl #(.REG_W(3), .MISS_MAX(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hit_fetch    (hit_fetch),
    .miss_done    (miss_done),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .branch_taken (branch_taken),
    .pc_write     (pc_write),
    .ifid_write   (ifid_write),
    .ifid_flush   (ifid_flush),
    .idex_bubble  (idex_bubble),
    .miss_err     (miss_err)
`ifdef PIPELINE_CTRL_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    hit_fetch = 1'b1; miss_done = 1'b0; ex_mem_read = 1'b0; branch_taken = 1'b0;
    id_rs1 = 3'd0; id_rs2 = 3'd0; ex_rd = 3'd0;
  endtask

  // Check outputs and miss_err mid-cycle, then advance to just after the next edge.
  task automatic cyc(input string tag, input logic [3:0] exp_out, input logic exp_err);
    @(negedge clk);
    chk({tag, "_out"}, {28'd0, pc_write, ifid_write, ifid_flush, idex_bubble}, {28'd0, exp_out});
    chk({tag, "_err"}, {31'd0, miss_err}, {31'd0, exp_err});
    @(posedge clk); #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    cyc("rst_run", NORM, 1'b0);
    hit_fetch = 1'b0;
    cyc("rst_miss_decode", STALL, 1'b0);
    hit_fetch = 1'b1;
    rst_n = 1'b1;
    cyc("post_rst", NORM, 1'b0);

    // Load-use hazards
    ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3;
    cyc("lu_rs2", STALL, 1'b0);
    idle();
    cyc("lu_after", NORM, 1'b0);
    ex_mem_read = 1'b1; ex_rd = 3'd0;
    cyc("lu_rd0", NORM, 1'b0);
    ex_rd = 3'd5; id_rs1 = 3'd5;
    cyc("lu_rs1", STALL, 1'b0);
    ex_mem_read = 1'b0;
    cyc("lu_noload", NORM, 1'b0);
    idle();

    // Stray miss_done in RUN is ignored
    miss_done = 1'b1;
    cyc("md_run", NORM, 1'b0);
    miss_done = 1'b0;
    cyc("md_run_next", NORM, 1'b0);

    // Plain miss: refill completes in the 4th wait cycle
    hit_fetch = 1'b0;
    cyc("miss_run", STALL, 1'b0);
    hit_fetch = 1'b1;
    cyc("miss_w1", STALL, 1'b0);
    cyc("miss_w2", STALL, 1'b0);
    cyc("miss_w3", STALL, 1'b0);
    miss_done = 1'b1;
    cyc("miss_w4", STALL, 1'b0);
    miss_done = 1'b0;
    cyc("miss_back", NORM, 1'b0);

    // Branch in the 2nd wait cycle, refill later -> one FLUSH cycle
    hit_fetch = 1'b0;
    cyc("bm_run", STALL, 1'b0);
    hit_fetch = 1'b1;
    cyc("bm_w1", STALL, 1'b0);
    branch_taken = 1'b1;
    cyc("bm_w2_br", BRMW, 1'b0);
    branch_taken = 1'b0; miss_done = 1'b1;
    cyc("bm_w3_done", STALL, 1'b0);
    miss_done = 1'b0;
    cyc("bm_flush", FLSH, 1'b0);
    cyc("bm_run_back", NORM, 1'b0);

    // Branch coincident with refill, then branch during FLUSH
    hit_fetch = 1'b0;
    cyc("bc_run", STALL, 1'b0);
    hit_fetch = 1'b1; branch_taken = 1'b1; miss_done = 1'b1;
    cyc("bc_w1", BRMW, 1'b0);
    miss_done = 1'b0;
    cyc("bc_flush_br", FLSH, 1'b0);
    branch_taken = 1'b0;
    cyc("bc_run_back", NORM, 1'b0);

    // Priority: branch beats miss and load-use; state stays RUN
    branch_taken = 1'b1; hit_fetch = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2;
    cyc("prio", FLSH, 1'b0);
    idle();
    cyc("prio_next", NORM, 1'b0);

    // Timeout: 10 wait cycles, miss_err visible from the 9th onward
    hit_fetch = 1'b0;
    cyc("to_run", STALL, 1'b0);
    hit_fetch = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      if (i == 10) miss_done = 1'b1;
      cyc($sformatf("to_w%0d", i), STALL, (i >= 9));
    end
    miss_done = 1'b0;
    cyc("to_exit", NORM, 1'b1);

    // Reset mid-miss with a pending flush discards it and clears miss_err
    hit_fetch = 1'b0;
    cyc("rm_run", STALL, 1'b1);
    hit_fetch = 1'b1; branch_taken = 1'b1;
    cyc("rm_w1_br", BRMW, 1'b1);
    branch_taken = 1'b0;
    rst_n = 1'b0;
    cyc("rm_in_rst", NORM, 1'b0);
    rst_n = 1'b1;
    cyc("rm_after", NORM, 1'b0);
    hit_fetch = 1'b0;
    cyc("rm2_run", STALL, 1'b0);
    hit_fetch = 1'b1; miss_done = 1'b1;
    cyc("rm2_w1_done", STALL, 1'b0);
    miss_done = 1'b0;
    cyc("rm2_no_flush", NORM, 1'b0);

`ifdef PIPELINE_CTRL_STALL_CNT_EN
    rst_n = 1'b0;
    @(negedge clk);
    chk("stall_rst", {16'd0, stall_cycles}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ex_mem_read = 1'b1; ex_rd = 3'd4; id_rs1 = 3'd4;
    cyc("sc_s1", STALL, 1'b0);
    cyc("sc_s2", STALL, 1'b0);
    cyc("sc_s3", STALL, 1'b0);
    idle();
    cyc("sc_norm", NORM, 1'b0);
    chk("stall_cnt", {16'd0, stall_cycles}, 32'd3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
